mdio_controller: RTL



---
 rtl/mdio_pkg.sv | 62 ++++++
 rtl/mdio_if.sv | 32 +++
 rtl/mdio_rx_shifter.sv | 34 +++
 rtl/mdio_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared definitions for the MDIO station-management sequencer.
//   - state encoding (localparams + enum)
//   - frame field constants and bit positions
//   - phase lengths and small helpers used by the controller
package mdio_pkg;

  localparam int CNT_W = 6;

  localparam logic [2:0] S_IDLE_ENC  = 3'd0;
  localparam logic [2:0] S_PRE_ENC   = 3'd1;
  localparam logic [2:0] S_FRAME_ENC = 3'd2;
  localparam logic [2:0] S_TURN_ENC  = 3'd3;
  localparam logic [2:0] S_READ_ENC  = 3'd4;
  localparam logic [2:0] S_DONE_ENC  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = S_IDLE_ENC,
    S_PRE   = S_PRE_ENC,
    S_FRAME = S_FRAME_ENC,
    S_TURN  = S_TURN_ENC,
    S_READ  = S_READ_ENC,
    S_DONE  = S_DONE_ENC
  } state_t;

  localparam logic [1:0] ST_VAL = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  localparam int ST_HI    = 31;
  localparam int ST_LO    = 30;
  localparam int OP_HI    = 29;
  localparam int OP_LO    = 28;
  localparam int PHYAD_HI = 27;
  localparam int PHYAD_LO = 23;
  localparam int REGAD_HI = 22;
  localparam int REGAD_LO = 18;
  localparam int TA_HI    = 17;
  localparam int TA_LO    = 16;
  localparam int DATA_HI  = 15;
  localparam int DATA_LO  = 0;

  localparam int FRAME_BITS    = 32;
  localparam int READ_HDR_BITS = 14;
  localparam int TURN_BITS     = 2;
  localparam int DATA_BITS     = 16;

  function automatic logic frame_valid(input logic [31:0] f);
    return (f[ST_HI:ST_LO] == ST_VAL) &&
           ((f[OP_HI:OP_LO] == OP_WR) || (f[OP_HI:OP_LO] == OP_RD));
  endfunction

  function automatic logic frame_is_rd(input logic [31:0] f);
    return f[OP_HI:OP_LO] == OP_RD;
  endfunction

  // Remaining-bit count loaded when the first frame bit goes out: the
  // frame phase then runs until the counter reaches zero.
  function automatic logic [CNT_W-1:0] frame_cnt_init(input logic is_rd);
    return is_rd ? CNT_W'(READ_HDR_BITS - 1) : CNT_W'(FRAME_BITS - 1);
  endfunction

endpackage

// File: rtl/mdio_if.sv
// mdio_if: request/response and serial-line bundle of the MDIO controller.
//   t_data[31:0]  management frame (ST/OP/PHYAD/REGAD/TA/data)
//   mdio_start    begin transaction
//   mdio_in       serial data from the PHY
//   mdio_out      serial data to the PHY
//   mdio_oe       controller owns the bus
//   busy          controller not idle
//   mdio_done     one-cycle completion pulse
//   mdio_err      one-cycle rejected-frame pulse (with mdio_done)
//   rd_data[15:0] last read result
// master: host/PHY side driving requests and mdio_in; slave: the controller.
interface mdio_if;
  logic [31:0] t_data;
  logic        mdio_start;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic        busy;
  logic        mdio_done;
  logic        mdio_err;
  logic [15:0] rd_data;

  modport master (
    output t_data, mdio_start, mdio_in,
    input  mdio_out, mdio_oe, busy, mdio_done, mdio_err, rd_data
  );

  modport slave (
    input  t_data, mdio_start, mdio_in,
    output mdio_out, mdio_oe, busy, mdio_done, mdio_err, rd_data
  );
endinterface

// File: rtl/mdio_rx_shifter.sv
// mdio_rx_shifter: MSB-first receive shifter for the read data phase.
//   MDC         management clock
//   rst         async active-low reset
//   shift_en_i  shift mdio_in_i in on this edge
//   mdio_in_i   serial data from the PHY
//   word_o      16-bit word as it stands once the current bit is taken
// Only 15 history bits are stored; the 16th is the live input bit so the
// controller can capture the complete word on the final sampling edge.
module mdio_rx_shifter
  import mdio_pkg::*;
(
  input  logic                 MDC,
  input  logic                 rst,
  input  logic                 shift_en_i,
  input  logic                 mdio_in_i,
  output logic [DATA_BITS-1:0] word_o
);

  logic [DATA_BITS-2:0] word_q;
  logic [DATA_BITS-2:0] word_d;

  assign word_o = {word_q, mdio_in_i};

  always_comb begin
    word_d = word_q;
    if (shift_en_i) word_d = word_o[DATA_BITS-2:0];
  end

  always_ff @(posedge MDC or negedge rst) begin
    if (!rst) word_q <= '0;
    else      word_q <= word_d;
  end

endmodule

// File: rtl/mdio_controller.sv
// mdio_controller: STA-side MDIO sequencer. Sends PREAMBLE_LEN ones, then
// the 32-bit frame MSB-first; read frames release the bus at turnaround
// and shift in 16 data bits. All outputs are registered.
//   MDC   management clock (all state changes on posedge)
//   rst   async active-low reset
//   bus   mdio_if.slave (request, serial lines, status, rd_data)
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | bus released, waiting for mdio_start
// PRE     | driving preamble ones
// FRAME   | driving frame bits (32 for write, 14 header bits for read)
// TURN    | read turnaround, bus released for two cycles
// READ    | sampling 16 data bits from mdio_in
// DONE    | one-cycle mdio_done (and mdio_err for rejected frames)
module mdio_controller
  import mdio_pkg::*;
#(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic MDC,
  input  logic rst,
  mdio_if.slave bus
);

  localparam logic [CNT_W-1:0] PRE_INIT =
    (PREAMBLE_LEN > 0) ? CNT_W'(PREAMBLE_LEN - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic             is_rd_q, is_rd_d;
  logic             out_q, out_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      rd_q, rd_d;
  logic             rx_en;
  logic [15:0]      rx_word;

  mdio_rx_shifter u_rx (
    .MDC        (MDC),
    .rst        (rst),
    .shift_en_i (rx_en),
    .mdio_in_i  (bus.mdio_in),
    .word_o     (rx_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    is_rd_d = is_rd_q;
    out_d   = 1'b0;
    oe_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = rd_q;
    rx_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.mdio_start) begin
          shift_d = bus.t_data;
          is_rd_d = frame_is_rd(bus.t_data);
          busy_d  = 1'b1;
          if (!frame_valid(bus.t_data)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (PREAMBLE_LEN > 0) begin
            state_d = S_PRE;
            oe_d    = 1'b1;
            out_d   = 1'b1;
            cnt_d   = PRE_INIT;
          end else begin
            // No preamble: the first frame bit goes out on the start edge.
            state_d = S_FRAME;
            oe_d    = 1'b1;
            out_d   = bus.t_data[31];
            shift_d = {bus.t_data[30:0], 1'b0};
            cnt_d   = frame_cnt_init(frame_is_rd(bus.t_data));
          end
        end
      end

      S_PRE: begin
        oe_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_FRAME;
          out_d   = shift_q[31];
          shift_d = {shift_q[30:0], 1'b0};
          cnt_d   = frame_cnt_init(is_rd_q);
        end else begin
          out_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FRAME: begin
        if (cnt_q == '0) begin
          if (is_rd_q) begin
            state_d = S_TURN;
            cnt_d   = CNT_W'(TURN_BITS - 1);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          oe_d    = 1'b1;
          out_d   = shift_q[31];
          shift_d = {shift_q[30:0], 1'b0};
          cnt_d   = cnt_q - 1'b1;
        end
      end

      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_READ;
          cnt_d   = CNT_W'(DATA_BITS - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_READ: begin
        rx_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          rd_d    = rx_word;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MDC or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      is_rd_q <= 1'b0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      is_rd_q <= is_rd_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.mdio_out  = out_q;
  assign bus.mdio_oe   = oe_q;
  assign bus.busy      = busy_q;
  assign bus.mdio_done = done_q;
  assign bus.mdio_err  = err_q;
  assign bus.rd_data   = rd_q;

endmodule
